// File: rtl/ls_control_unit_if.sv
// Control-unit bundle: instruction/memory/run inputs and all datapath control strobes.
// master = control unit, slave = datapath/memory side.
interface ls_control_unit_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        run;
  logic        PCout, Zlowout, MDRout, Rout, BAout, Cout;
  logic        PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, Rin;
  logic        Gra, Grb;
  logic        IncPC, Read, Write;
  logic [4:0]  op;
  logic [3:0]  state;
  logic        halted;
  logic        illegal;

  modport master (
    input  IR, mem_ready, run,
    output PCout, Zlowout, MDRout, Rout, BAout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, Rin,
    output Gra, Grb, IncPC, Read, Write, op, state, halted, illegal
  );

  modport slave (
    output IR, mem_ready, run,
    input  PCout, Zlowout, MDRout, Rout, BAout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, Rin,
    input  Gra, Grb, IncPC, Read, Write, op, state, halted, illegal
  );
endinterface

// File: rtl/ls_control_unit.sv
// Load/store control sequencer: Moore outputs decoded from state and opcode, zero latency from state.
// Memory waits stall in T1/T6(ld)/T7(st) until mem_ready; run gates fetch at instruction end.
module ls_control_unit (
  input  logic                 Clock,
  input  logic                 clear,
  ls_control_unit_if.master    bus
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    T7   = 4'd8,
    HALT = 4'd9
  } state_t;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD  = 5'b00011;

  state_t     state_q, state_d, end_state;
  logic       prev_not_t1;
  logic [4:0] opc;
  logic       is_ld, is_ldi, is_st, is_mem;
  logic       unused_ir;

  assign opc       = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  assign is_ld     = (opc == OPC_LD);
  assign is_ldi    = (opc == OPC_LDI);
  assign is_st     = (opc == OPC_ST);
  assign is_mem    = is_ld | is_ldi | is_st;
  assign end_state = bus.run ? T0 : IDLE;
  assign bus.state = state_q;

  // prev_not_t1 marks the first cycle of a fetch wait so PC is loaded only once.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      prev_not_t1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_not_t1 <= (state_q != T1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.PCin    = 1'b0;
    bus.IRin    = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.Yin     = 1'b0;
    bus.ZHighin = 1'b0;
    bus.Zlowin  = 1'b0;
    bus.Rin     = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.op      = 5'b00000;
    bus.halted  = 1'b0;
    bus.illegal = 1'b0;

    case (state_q)
      IDLE: if (bus.run) state_d = T0;
      T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.ZHighin = 1'b1;
        bus.Zlowin  = 1'b1;
        state_d     = T1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = prev_not_t1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (bus.mem_ready) state_d = T2;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = T3;
      end
      T3: begin
        if (is_mem) begin
          bus.Grb   = 1'b1;
          bus.BAout = 1'b1;
          bus.Yin   = 1'b1;
          state_d   = T4;
        end else if (opc == OPC_NOP) begin
          state_d = end_state;
        end else if (opc == OPC_HALT) begin
          state_d = HALT;
        end else begin
          bus.illegal = 1'b1;
          state_d     = end_state;
        end
      end
      T4: begin
        if (is_mem) begin
          bus.Cout    = 1'b1;
          bus.op      = ALU_ADD;
          bus.ZHighin = 1'b1;
          bus.Zlowin  = 1'b1;
          state_d     = T5;
        end else begin
          state_d = IDLE;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (is_ldi) begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
          state_d = end_state;
        end else if (is_ld || is_st) begin
          bus.MARin = 1'b1;
          state_d   = T6;
        end else begin
          bus.Zlowout = 1'b0;
          state_d     = IDLE;
        end
      end
      T6: begin
        if (is_ld) begin
          bus.Read  = 1'b1;
          bus.MDRin = 1'b1;
          if (bus.mem_ready) state_d = T7;
        end else if (is_st) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.MDRin = 1'b1;
          state_d   = T7;
        end else begin
          state_d = IDLE;
        end
      end
      T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
          state_d    = end_state;
        end else if (is_st) begin
          bus.Write = 1'b1;
          if (bus.mem_ready) state_d = end_state;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: bus.halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ls_control_unit.sv
// Directed vector bench for ls_control_unit: state and full control word checked every cycle.
module tb_ls_control_unit;
  logic Clock;
  logic clear;

  ls_control_unit_if bus ();

  ls_control_unit dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [25:0] PCOUT   = 26'd1 << 25;
  localparam logic [25:0] ZLOWOUT = 26'd1 << 24;
  localparam logic [25:0] MDROUT  = 26'd1 << 23;
  localparam logic [25:0] ROUT    = 26'd1 << 22;
  localparam logic [25:0] BAOUT   = 26'd1 << 21;
  localparam logic [25:0] COUT    = 26'd1 << 20;
  localparam logic [25:0] PCIN    = 26'd1 << 19;
  localparam logic [25:0] IRIN    = 26'd1 << 18;
  localparam logic [25:0] MARIN   = 26'd1 << 17;
  localparam logic [25:0] MDRIN   = 26'd1 << 16;
  localparam logic [25:0] YIN     = 26'd1 << 15;
  localparam logic [25:0] ZHIGHIN = 26'd1 << 14;
  localparam logic [25:0] ZLOWIN  = 26'd1 << 13;
  localparam logic [25:0] RIN     = 26'd1 << 12;
  localparam logic [25:0] GRA     = 26'd1 << 11;
  localparam logic [25:0] GRB     = 26'd1 << 10;
  localparam logic [25:0] INCPC   = 26'd1 << 9;
  localparam logic [25:0] READ    = 26'd1 << 8;
  localparam logic [25:0] WRITE   = 26'd1 << 7;
  localparam logic [25:0] HALTED  = 26'd1 << 6;
  localparam logic [25:0] ILLEGAL = 26'd1 << 5;
  localparam logic [25:0] OP_ADD  = 26'd3;

  localparam logic [25:0] W_T0  = PCOUT | MARIN | INCPC | ZHIGHIN | ZLOWIN;
  localparam logic [25:0] W_T1F = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [25:0] W_T1W = ZLOWOUT | READ | MDRIN;
  localparam logic [25:0] W_T2  = MDROUT | IRIN;
  localparam logic [25:0] W_T3  = GRB | BAOUT | YIN;
  localparam logic [25:0] W_T4  = COUT | OP_ADD | ZHIGHIN | ZLOWIN;
  localparam logic [25:0] W_T5I = ZLOWOUT | GRA | RIN;
  localparam logic [25:0] W_T5  = ZLOWOUT | MARIN;
  localparam logic [25:0] W_T6L = READ | MDRIN;
  localparam logic [25:0] W_T6S = GRA | ROUT | MDRIN;
  localparam logic [25:0] W_T7L = MDROUT | GRA | RIN;
  localparam logic [25:0] W_T7S = WRITE;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
  localparam logic [4:0] NOP = 5'b11010, HLT = 5'b11011, BAD = 5'b10101;

  typedef struct {
    logic       run;
    logic       mr;
    logic [4:0] opc;
    logic [3:0] st;
    logic [25:0] w;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [25:0] dut_word;
  assign dut_word = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Cout,
                     bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.ZHighin,
                     bus.Zlowin, bus.Rin, bus.Gra, bus.Grb, bus.IncPC, bus.Read,
                     bus.Write, bus.halted, bus.illegal, bus.op};

  task automatic add(input logic r, input logic m, input logic [4:0] o,
                     input logic [3:0] s, input logic [25:0] w);
    vecs.push_back('{r, m, o, s, w});
  endtask

  // Compares state and control word, and also checks the Read/Write and single-driver invariants.
  task automatic check_now(input logic [3:0] s, input logic [25:0] w, input string name);
    n_vec++;
    if (bus.state !== s || dut_word !== w ||
        (bus.Read && bus.Write) || ($countones(dut_word[25:20]) > 1)) begin
      n_err++;
      $display("FAIL %s: state=%0d word=%07h, required state=%0d word=%07h",
               name, bus.state, dut_word, s, w);
    end
  endtask

  task automatic apply(input logic r, input logic m, input logic [4:0] o,
                       input logic [3:0] s, input logic [25:0] w, input string name);
    @(negedge Clock);
    bus.run       = r;
    bus.mem_ready = m;
    bus.IR        = {o, 27'h0};
    #1;
    check_now(s, w, name);
  endtask

  initial begin
    clear         = 1'b0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR        = 32'h0;

    // ld, no waits
    add(1,1,LD,0,0);     add(1,1,LD,1,W_T0);  add(1,1,LD,2,W_T1F); add(1,1,LD,3,W_T2);
    add(1,1,LD,4,W_T3);  add(1,1,LD,5,W_T4);  add(1,1,LD,6,W_T5);  add(1,1,LD,7,W_T6L);
    add(1,1,LD,8,W_T7L);
    // ld with one fetch wait and three T6 waits
    add(1,1,LD,1,W_T0);  add(1,0,LD,2,W_T1F); add(1,1,LD,2,W_T1W); add(1,1,LD,3,W_T2);
    add(1,1,LD,4,W_T3);  add(1,1,LD,5,W_T4);  add(1,1,LD,6,W_T5);  add(1,0,LD,7,W_T6L);
    add(1,0,LD,7,W_T6L); add(1,0,LD,7,W_T6L); add(1,1,LD,7,W_T6L); add(1,1,LD,8,W_T7L);
    // st, mem_ready low outside wait states is ignored; two T7 waits
    add(1,0,ST,1,W_T0);  add(1,1,ST,2,W_T1F); add(1,0,ST,3,W_T2);  add(1,1,ST,4,W_T3);
    add(1,1,ST,5,W_T4);  add(1,1,ST,6,W_T5);  add(1,0,ST,7,W_T6S); add(1,0,ST,8,W_T7S);
    add(1,0,ST,8,W_T7S); add(1,1,ST,8,W_T7S);
    // ldi
    add(1,1,LDI,1,W_T0); add(1,1,LDI,2,W_T1F); add(1,1,LDI,3,W_T2); add(1,1,LDI,4,W_T3);
    add(1,1,LDI,5,W_T4); add(1,1,LDI,6,W_T5I);
    // nop
    add(1,1,NOP,1,W_T0); add(1,1,NOP,2,W_T1F); add(1,1,NOP,3,W_T2); add(1,1,NOP,4,0);
    // illegal with run dropped at instruction end
    add(1,1,BAD,1,W_T0); add(1,1,BAD,2,W_T1F); add(1,1,BAD,3,W_T2); add(0,1,BAD,4,ILLEGAL);
    add(0,1,BAD,0,0);    add(1,1,BAD,0,0);
    // halt
    add(1,1,HLT,1,W_T0); add(1,1,HLT,2,W_T1F); add(1,1,HLT,3,W_T2); add(1,1,HLT,4,0);
    add(1,1,HLT,9,HALTED); add(1,1,HLT,9,HALTED); add(1,0,HLT,9,HALTED);

    #2;
    check_now(0, 0, "reset_state");
    @(negedge Clock);
    clear = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].run, vecs[i].mr, vecs[i].opc, vecs[i].st, vecs[i].w, $sformatf("vec%0d", i));

    // clear out of HALT, asynchronously between edges
    @(negedge Clock);
    #2 clear = 1'b0;
    #1 check_now(0, 0, "halt_clear");
    bus.run = 1'b0;
    @(negedge Clock);
    clear = 1'b1;

    // reset during a T6 memory wait
    apply(1,1,LD,0,0,"rst_idle");     apply(1,1,LD,1,W_T0,"rst_t0");
    apply(1,1,LD,2,W_T1F,"rst_t1");   apply(1,1,LD,3,W_T2,"rst_t2");
    apply(1,1,LD,4,W_T3,"rst_t3");    apply(1,1,LD,5,W_T4,"rst_t4");
    apply(1,1,LD,6,W_T5,"rst_t5");    apply(1,0,LD,7,W_T6L,"rst_t6");
    @(posedge Clock);
    #3 clear = 1'b0;
    #1 check_now(0, 0, "reset_mid_t6");
    bus.run = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    apply(0,1,LD,0,0,"post_idle0");
    apply(0,1,LD,0,0,"post_idle1");
    apply(0,1,LD,0,0,"post_idle2");
    apply(1,1,LD,0,0,"post_run");
    apply(0,1,LD,1,W_T0,"post_t0");
    apply(0,1,LD,2,W_T1F,"post_t1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ls_control_unit.md
LS_CONTROL_UNIT -- requirements
Module: ls_control_unit

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, asynchronous, active-low; one clock, no other clock or reset.
REQ-003 IR  input  32  instruction register contents; opcode IR[31:27]; stable from end of T2 until next T0.
REQ-004 mem_ready  input  1  memory completes the pending Read/Write this cycle.
REQ-005 run  input  1  permit fetch of the next instruction.
REQ-006 PCout, Zlowout, MDRout, Rout, BAout, Cout  output  1 each  bus-driver selects.
REQ-007 PCin, IRin, MARin, MDRin, Yin, ZHighin, Zlowin, Rin  output  1 each  register load enables.
REQ-008 Gra, Grb  output  1 each  register-field selects for Rin/Rout/BAout.
REQ-009 IncPC, Read, Write  output  1 each  PC increment and memory strobes.
REQ-010 op  output  5  ALU operation; 5'b00011 = ADD, 5'b00000 = idle.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 halted  output  1  high while in HALT.
REQ-013 illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-014 States and encodings SHALL be IDLE=0, T0..T7=1..8, HALT=9; state register updates on rising Clock.
REQ-015 All outputs SHALL be Moore-decoded from state and IR[31:27]; unlisted outputs 0, op=00000.
REQ-016 IDLE: go to T0 when run=1, else hold.
REQ-017 T0: PCout, MARin, IncPC, ZHighin, Zlowin; go to T1.
REQ-018 T1: Zlowout, PCin, Read, MDRin; hold in T1 while mem_ready=0, with PCin asserted only in the first T1 cycle; go to T2 when mem_ready=1.
REQ-019 T2: MDRout, IRin; go to T3.
REQ-020 Opcodes: ld=00000, ldi=00001, st=00010, nop=11010, halt=11011; any other value is illegal.
REQ-021 T3 for ld/ldi/st: Grb, BAout, Yin; go to T4.
REQ-022 T4 for ld/ldi/st: Cout, op=00011, ZHighin, Zlowin; go to T5.
REQ-023 T5 for ldi: Zlowout, Gra, Rin; instruction end.
REQ-024 T5 for ld/st: Zlowout, MARin; go to T6.
REQ-025 T6 for ld: Read, MDRin; hold while mem_ready=0; go to T7 on mem_ready=1.
REQ-026 T6 for st: Gra, Rout, MDRin, Read=0; go to T7.
REQ-027 T7 for ld: MDRout, Gra, Rin; instruction end.
REQ-028 T7 for st: Write; hold while mem_ready=0; instruction end on mem_ready=1.
REQ-029 T3 for nop: no signals; instruction end.
REQ-030 T3 for illegal: illegal=1 for exactly one cycle; instruction end.
REQ-031 T3 for halt: go to HALT; HALT holds and sets halted=1 until reset.
REQ-032 Instruction end: go to T0 if run=1, else IDLE; run is sampled only at instruction end and in IDLE.
REQ-033 Never assert Read and Write in the same cycle; assert at most one bus driver per cycle.
REQ-034 mem_ready outside T1/T6(ld)/T7(st) SHALL be ignored.

Reset
REQ-035 clear=0 SHALL force state=IDLE immediately, independent of Clock, and drive all outputs to 0 (op=00000, halted=0, illegal=0).
REQ-036 Reset mid-instruction, including during a memory wait, SHALL abandon the instruction; the first fetch after release starts at T0 once run=1.

Verification
REQ-037 ld: run=1, mem_ready=1 always, IR=0x00000000 -> states 1..8 then 1, with Read in T1 and T6 and Rin only in T7.
REQ-038 ld with wait: mem_ready=0 for 3 cycles in T6 -> state=7 held for 4 cycles, Read=MDRin=1 throughout, then T7.
REQ-039 st: IR[31:27]=00010, mem_ready low 2 cycles in T7 -> Write=1 for 3 cycles, Read=0 all of T6/T7, then T0.
REQ-040 ldi: IR[31:27]=00001 -> T5 asserts Zlowout, Gra, Rin; next state T0; no Read after T1.
REQ-041 halt then illegal: IR[31:27]=11011 -> state=9, halted=1 stays; separately IR[31:27]=10101 -> illegal=1 for one cycle at T3.
REQ-042 Reset: clear=0 mid-T6 between clock edges -> state=0 and Read=0 before the next edge; with run=0 after release, stays IDLE.
